vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
Generates VGA 640x480@60 raster timing: hsync, vsync, pixel-enable, current pixel coordinates and a per-frame pulse. Drives the x/y/pxl_en/frame_pulse inputs of the pixel generator and the sync pins of the DAC/connector. Runs from the 50 MHz system clock and derives the pixel rate internally via a clock-enable divider; no second clock domain.

Parameters:
CLK_DIV, 2, clk cycles per pixel (>=1); 2 gives 25 MHz pixel rate from 50 MHz.
H_ACTIVE, 640, visible pixels per line.
H_FP, 16, horizontal front porch (pixels).
H_SYNC, 96, hsync pulse width (pixels).
H_BP, 48, horizontal back porch (pixels).
V_ACTIVE, 480, visible lines per frame.
V_FP, 10, vertical front porch (lines).
V_SYNC, 2, vsync pulse width (lines).
V_BP, 33, vertical back porch (lines).

Ports:
clk  in  1  system clock (50 MHz)
rst  in  1  asynchronous, active-high reset
pxl_tick  out  1  pixel clock-enable, high 1 clk every CLK_DIV clks
hsync  out  1  horizontal sync, active low
vsync  out  1  vertical sync, active low
pxl_en  out  1  high while position is inside the visible area
x  out  10  horizontal pixel coordinate, 0 outside visible area
y  out  10  vertical line coordinate, 0 outside visible area
frame_pulse  out  1  one-clk pulse at start of vertical blanking

Behaviour:
- Reset is rst, asynchronous, active-high; clock is clk. All state is on posedge clk / posedge rst.
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Divider div_cnt counts 0..CLK_DIV-1 and wraps. pxl_tick = (div_cnt == CLK_DIV-1), combinational from div_cnt. With CLK_DIV=1, pxl_tick is constantly high (outside reset).
- Position counters h_cnt (0..H_TOTAL-1) and v_cnt (0..V_TOTAL-1) advance only on clk edges where pxl_tick=1. h_cnt wraps H_TOTAL-1 -> 0 and increments v_cnt on that same edge. v_cnt wraps V_TOTAL-1 -> 0 when h_cnt wraps.
- Reset values: div_cnt=0, h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1. Consequently, the first tick after reset moves position to (0,0).
- Output registers are updated on the same edge as the counters and decode the new position (no extra pipeline stage):
  - pxl_en = h<H_ACTIVE && v<V_ACTIVE.
  - x = h when pxl_en, else 0. y = v when pxl_en, else 0.
  - hsync = 0 iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vsync = 0 iff V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (490..491), over the full line width.
- frame_pulse is high for exactly one clk (not one tick) following the edge that moves position to (0,V_ACTIVE). It is 0 on all other cycles.
- Between ticks, all outputs except pxl_tick hold their values.
- Reset output values: hsync=1, vsync=1, pxl_en=0, x=0, y=0, frame_pulse=0. pxl_tick=0 when CLK_DIV>1.
- Reset asserted mid-frame: all outputs return to their reset values immediately (asynchronously). On release, timing restarts with the first tick at the CLK_DIV-th edge, landing at position (0,0).
- Counter widths are 10 bits; parameter sets must keep H_TOTAL and V_TOTAL <= 1024.

Optional Feature:
VGA_TEST_PATTERN_EN:
- Defined: adds outputs r, g, b (1 bit each), registered with the same timing as pxl_en. When pxl_en=1, {r,g,b} = 3'b111 - x[8:6], giving 64-pixel-wide colour bars: x=0..63 white, x=64..127 3'b110, and so on. When pxl_en=0, {r,g,b} = 3'b000. Reset value is 0.
- Undefined: the ports and the associated logic are absent.

Test Plan:
- Reset, release, CLK_DIV=2 -> pxl_tick high every 2nd clk. On the 2nd edge after release: pxl_en=1, x=0, y=0, hsync=1, vsync=1.
- Run one line -> pxl_en high for exactly 640 ticks (1280 clk); x increments 0..639; hsync low for 96 ticks starting at h=656; line period 1600 clk.
- Run a full frame -> pxl_en lines y=0..479. vsync low for exactly 2 lines (v=490,491; 3200 clk). frame_pulse is 1 clk wide, first seen 480 lines after (0,0); next pulse 840000 clk later.
- Assert rst mid-line at h=300, v=200 for 3 clk -> outputs immediately take reset values. After release, the first tick gives (0,0), with no frame_pulse until 480 lines later.
- Parameter override CLK_DIV=1 -> pxl_tick constant 1; line period 800 clk; frame period 420000 clk.
- With VGA_TEST_PATTERN_EN defined -> x=0: rgb=111; x=64: rgb=110; x=448: rgb=000; blanking: rgb=000.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster timing with clock-enable pixel divider.
// Define VGA_TEST_PATTERN_EN to add r/g/b colour-bar outputs.
module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pxl_tick,
  output logic       hsync,
  output logic       vsync,
  output logic       pxl_en,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       frame_pulse
`ifdef VGA_TEST_PATTERN_EN
  ,
  output logic       r,
  output logic       g,
  output logic       b
`endif
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [9:0] H_MAX  = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_MAX  = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [9:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d, h_nxt, v_nxt;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic hsync_q, hsync_d, vsync_q, vsync_d, pxl_en_q, pxl_en_d;
  logic frame_pulse_q, frame_pulse_d, vis;
`ifdef VGA_TEST_PATTERN_EN
  logic [2:0] rgb_q, rgb_d;
  assign {r, g, b} = rgb_q;
`endif
  assign pxl_tick    = div_cnt_q == DIV_MAX;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign pxl_en      = pxl_en_q;
  assign x           = x_q;
  assign y           = y_q;
  assign frame_pulse = frame_pulse_q;
  // Outputs decode the position the counters are about to take, so they line up with it.
  always_comb begin
    h_nxt         = h_cnt_q == H_MAX ? '0 : h_cnt_q + 10'd1;
    v_nxt         = h_cnt_q != H_MAX ? v_cnt_q : v_cnt_q == V_MAX ? '0 : v_cnt_q + 10'd1;
    vis           = h_nxt < H_ACT && v_nxt < V_ACT;
    div_cnt_d     = pxl_tick ? '0 : div_cnt_q + DW'(1);
    h_cnt_d       = pxl_tick ? h_nxt : h_cnt_q;
    v_cnt_d       = pxl_tick ? v_nxt : v_cnt_q;
    pxl_en_d      = pxl_tick ? vis : pxl_en_q;
    x_d           = pxl_tick ? (vis ? h_nxt : '0) : x_q;
    y_d           = pxl_tick ? (vis ? v_nxt : '0) : y_q;
    hsync_d       = pxl_tick ? !(h_nxt >= HS_BEG && h_nxt < HS_END) : hsync_q;
    vsync_d       = pxl_tick ? !(v_nxt >= VS_BEG && v_nxt < VS_END) : vsync_q;
    frame_pulse_d = pxl_tick && h_nxt == '0 && v_nxt == V_ACT;
`ifdef VGA_TEST_PATTERN_EN
    rgb_d         = pxl_tick ? (vis ? 3'b111 - h_nxt[8:6] : '0) : rgb_q;
`endif
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q     <= '0;
      h_cnt_q       <= H_MAX;
      v_cnt_q       <= V_MAX;
      pxl_en_q      <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      frame_pulse_q <= 1'b0;
`ifdef VGA_TEST_PATTERN_EN
      rgb_q         <= '0;
`endif
    end else begin
      div_cnt_q     <= div_cnt_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      pxl_en_q      <= pxl_en_d;
      x_q           <= x_d;
      y_q           <= y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_pulse_q <= frame_pulse_d;
`ifdef VGA_TEST_PATTERN_EN
      rgb_q         <= rgb_d;
`endif
    end
  end
endmodule
